// File: rtl/ysyx_041514_pc_gen_pkg.sv
// Shared constants and state type for the PC generation / fetch request unit.
package ysyx_041514_pc_gen_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    PCG_IDLE = 2'd0,
    PCG_REQ  = 2'd1,
    PCG_WAIT = 2'd2,
    PCG_HOLD = 2'd3
  } pcg_state_t;

endpackage

// File: rtl/ysyx_041514_pc_gen.sv
// Fetch PC owner: issues one icache request at a time, presents the returned
// word to fetch, buffers it across downstream stalls, and steers on BPU/flush.
module ysyx_041514_pc_gen
  import ysyx_041514_pc_gen_pkg::*;
#(
  parameter logic [63:0] RESET_PC_P = RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            if_req_valid_o,
  input  logic            if_req_ready_i,
  output logic [XLEN-1:0] if_req_addr_o,
  input  logic            if_resp_valid_i,
  input  logic [XLEN-1:0] if_resp_data_i,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            if_rdata_valid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            bpu_pc_valid_i,
  input  logic [XLEN-1:0] bpu_pc_op1_i,
  input  logic [XLEN-1:0] bpu_pc_op2_i,
  input  logic            stall_valid_i,
  input  logic            flush_valid_i,
  input  logic [XLEN-1:0] flush_pc_i
);

  pcg_state_t      state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] seq_pc;

  // Target for the word leaving this cycle; BPU is only consulted at release.
  assign seq_pc = bpu_pc_valid_i ? (bpu_pc_op1_i + bpu_pc_op2_i) : (req_pc_q + 64'd4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= PCG_IDLE;
      req_pc_q  <= RESET_PC_P;
      next_pc_q <= RESET_PC_P;
      kill_q    <= 1'b0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      next_pc_q <= next_pc_d;
      kill_q    <= kill_d;
      buf_q     <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    next_pc_d = next_pc_q;
    kill_d    = kill_q;
    buf_d     = buf_q;
    unique case (state_q)
      PCG_IDLE: begin
        state_d  = PCG_REQ;
        req_pc_d = flush_valid_i ? flush_pc_i : RESET_PC_P;
        kill_d   = 1'b0;
      end
      PCG_REQ: begin
        // The request must stay stable until accepted, so a flush is deferred.
        if (flush_valid_i) begin
          kill_d    = 1'b1;
          next_pc_d = flush_pc_i;
        end
        if (if_req_ready_i) state_d = PCG_WAIT;
      end
      PCG_WAIT: begin
        if (if_resp_valid_i) begin
          if (flush_valid_i) begin
            req_pc_d = flush_pc_i;
            kill_d   = 1'b0;
            state_d  = PCG_REQ;
          end else if (kill_q) begin
            req_pc_d = next_pc_q;
            kill_d   = 1'b0;
            state_d  = PCG_REQ;
          end else if (!stall_valid_i) begin
            req_pc_d = seq_pc;
            state_d  = PCG_REQ;
          end else begin
            buf_d   = if_resp_data_i;
            state_d = PCG_HOLD;
          end
        end else if (flush_valid_i) begin
          kill_d    = 1'b1;
          next_pc_d = flush_pc_i;
        end
      end
      PCG_HOLD: begin
        if (flush_valid_i) begin
          req_pc_d = flush_pc_i;
          state_d  = PCG_REQ;
        end else if (!stall_valid_i) begin
          req_pc_d = seq_pc;
          state_d  = PCG_REQ;
        end
      end
      default: state_d = PCG_IDLE;
    endcase
  end

  always_comb begin
    if_req_valid_o   = (state_q == PCG_REQ);
    if_req_addr_o    = req_pc_q;
    inst_addr_o      = req_pc_q;
    if_rdata_valid_o = 1'b0;
    if_rdata_o       = buf_q;
    if (state_q == PCG_WAIT && if_resp_valid_i) begin
      if_rdata_o       = if_resp_data_i;
      if_rdata_valid_o = !kill_q && !flush_valid_i;
    end else if (state_q == PCG_HOLD) begin
      if_rdata_valid_o = !flush_valid_i;
    end
  end

endmodule

// File: doc/ysyx_041514_pc_gen.md
# ysyx_041514_pc_gen

PC generation and instruction-fetch request unit sitting directly upstream of `ysyx_041514_fetch`. Owns the architectural fetch PC, issues one outstanding request at a time to the icache, and presents the returned instruction word and its address to the fetch stage. Holds the word in a one-entry buffer while the backend stalls, and steers the next PC from the BPU target or a backend flush.

## Interface
- `RESET_PC`, 64'h8000_0000, first fetch address after reset
- `clk` in 1, core clock
- `rst` in 1, synchronous, active-low reset
- `if_req_valid_o` out 1, icache request valid
- `if_req_ready_i` in 1, icache accepts request
- `if_req_addr_o` out XLEN, request address
- `if_resp_valid_i` in 1, icache response valid; one-cycle pulse, never held
- `if_resp_data_i` in XLEN, icache response data
- `inst_addr_o` out XLEN, PC of the presented word; drives fetch `inst_addr_i`
- `if_rdata_valid_o` out 1, presented word valid; drives fetch `if_rdata_valid_i`
- `if_rdata_o` out XLEN, presented word; drives fetch `if_rdata_i`
- `bpu_pc_valid_i` in 1, predicted-taken flag from fetch
- `bpu_pc_op1_i`, `bpu_pc_op2_i` in XLEN, target operands from fetch
- `stall_valid_i` in 1, downstream (IF/ID) cannot accept this cycle
- `flush_valid_i` in 1, backend redirect (branch mispredict or trap)
- `flush_pc_i` in XLEN, redirect target

## Operation
- States:
  - IDLE: only after reset.
  - REQ: presenting a request.
  - WAIT: request accepted, awaiting response.
  - HOLD: word buffered, downstream stalled.
- Registers:
  - `req_pc_q`: address of the current transaction.
  - `next_pc_q`: address of the next request.
  - `kill_q`: discard the in-flight response.
  - `buf_q`: held word.
- IDLE → REQ unconditionally; `req_pc_q = RESET_PC`.
- REQ: `if_req_valid_o = 1`, `if_req_addr_o = req_pc_q`. Address and valid stay stable until `if_req_ready_i`; then → WAIT.
- WAIT, response arrives, `kill_q = 0`: present the word combinationally the same cycle.
  - `if_rdata_valid_o = 1`, `if_rdata_o = if_resp_data_i`, `inst_addr_o = req_pc_q`.
  - If `!stall_valid_i`: next PC = `bpu_pc_valid_i ? op1 + op2 : req_pc_q + 4`, load it into `req_pc_q`, → REQ.
  - Else: capture the word into `buf_q`, → HOLD.
- WAIT, response arrives, `kill_q = 1`: word dropped, `if_rdata_valid_o = 0`, `req_pc_q <= next_pc_q`, `kill_q <= 0`, → REQ.
- HOLD: `if_rdata_valid_o = 1`, `if_rdata_o = buf_q`.
  - When `!stall_valid_i`: compute next PC from that cycle's BPU inputs, as in WAIT; → REQ.
- Flush has highest priority:
  - IDLE or HOLD: `req_pc_q <= flush_pc_i`, buffer dropped, → REQ.
  - REQ not accepted this cycle: request stays unchanged; `kill_q <= 1`, `next_pc_q <= flush_pc_i`.
  - REQ accepted this cycle: → WAIT with `kill_q <= 1`, `next_pc_q <= flush_pc_i`.
  - WAIT without a response: `kill_q <= 1`, `next_pc_q <= flush_pc_i`.
  - WAIT with a response the same cycle: response dropped, `req_pc_q <= flush_pc_i`, → REQ.
  - Repeated flushes while `kill_q` is set: the last target wins.
- Presented valid is masked in any cycle `flush_valid_i = 1`.
- Arithmetic: 64-bit wrap-around, no carry out.
- PCs are used verbatim; misalignment is reported by fetch's trap bus, not here.
- BPU inputs are sampled only in the cycle the word is released downstream.

## Timing
- Reset values:
  - State IDLE; `if_req_valid_o = 0`, `if_rdata_valid_o = 0`.
  - `inst_addr_o = RESET_PC`, `if_req_addr_o = RESET_PC`, `if_rdata_o = 0`, `kill_q = 0`.
- First request appears in the cycle after `rst` is released, at address `RESET_PC`.
- Best case: request accepted in cycle N, response in N+1 (word presented in N+1), next request in N+2.
  - One instruction per two cycles.
- `if_rdata_valid_o` and `if_rdata_o` are combinational from the response in WAIT and registered in HOLD.
- Reset asserted mid-transaction returns to IDLE. Any later response is ignored until REQ is re-entered.

## Structure
- Add to `sysconfig.v`:
  - State encodings: `ysyx_041514_PCG_IDLE`, `ysyx_041514_PCG_REQ`, `ysyx_041514_PCG_WAIT`, `ysyx_041514_PCG_HOLD`.
  - `ysyx_041514_RESET_PC`.
- Single flat module; no sub-module. The hold buffer is one register plus the HOLD state.

## Test plan
- Reset release, `if_req_ready_i = 1`, response one cycle later with 0x00000013:
  - Request at 0x80000000, word presented with `inst_addr_o = 0x80000000`.
  - Next request at 0x80000004.
- `bpu_pc_valid_i = 1`, op1 = 0x80000010, op2 = 0x20 on delivery → next request at 0x80000030.
- `stall_valid_i` held 3 cycles across delivery:
  - Word held stable with `if_rdata_valid_o = 1`.
  - No new request until the cycle after stall drops.
- Flush to 0x80001000 while in WAIT:
  - Later response 0xDEADBEEF not presented.
  - Next request at 0x80001000.
- Flush asserted together with `stall_valid_i` and `bpu_pc_valid_i` in HOLD:
  - Buffer dropped; next request at the flush target.
- `if_req_ready_i = 0` for 4 cycles with a flush in cycle 2:
  - Address stays 0x80000000 until accepted.
  - That response is discarded; next request at the flush target.
